// File: rtl/gpio_out_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_out_seq_pkg : register map, bit positions and FSM encoding            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gpio_out_seq_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] c_reg_data   = 2'd0;
  localparam logic [1:0] c_reg_cmd    = 2'd1;
  localparam logic [1:0] c_reg_ctrl   = 2'd2;
  localparam logic [1:0] c_reg_status = 2'd3;

  localparam int c_ctrl_run    = 0;
  localparam int c_ctrl_flush  = 1;

  localparam int c_st_empty    = 0;
  localparam int c_st_full     = 1;
  localparam int c_st_busy     = 2;
  localparam int c_st_ovf      = 3;
  localparam int c_st_cnt_lsb  = 8;

  localparam state_t c_fsm_idle  = 2'd0;
  localparam state_t c_fsm_issue = 2'd1;
  localparam state_t c_fsm_wait  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/gpio_out_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_out_seq_if : CPU slave window into the write sequencer                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface gpio_out_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             cs;
  logic             wen;
  logic [1:0]       addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (output cs, output wen, output addr, output din, input dout);
  modport slave  (input cs, input wen, input addr, input din, output dout);
endinterface
`default_nettype wire

// File: rtl/gpio_seq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_seq_fifo : synchronous command FIFO with push/pop/flush and count     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gpio_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int EW    = 50
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       i_push,
  input  wire logic                       i_pop,
  input  wire logic                       i_flush,
  input  wire logic [EW-1:0]              i_wdata,
  output logic      [EW-1:0]              o_rdata,
  output logic                            o_full,
  output logic                            o_empty,
  output logic      [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // full is taken from the registered count, so a same-cycle pop never frees room
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full  & ~i_flush;
  assign w_pop   = i_pop  & ~o_empty & ~i_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/gpio_out_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_out_seq : replays queued {port,delay,data} writes onto the GPIO bank  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gpio_out_seq
  import gpio_out_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int DLY_W = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  gpio_out_seq_if.slave          bus,
  output logic                   g_cs,
  output logic                   g_wen,
  output logic      [1:0]        g_addr,
  output logic      [WIDTH-1:0]  g_din,
  output logic                   done
);

  localparam int EW = 2 + DLY_W + WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_data;
  logic             r_run;
  logic             r_ovf;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [DLY_W-1:0] r_cnt;
  logic [1:0]       r_last_addr;
  logic [WIDTH-1:0] r_last_din;
  logic             r_idle_entry;

  logic             w_wr, w_push, w_flush, w_pop;
  logic             w_full, w_empty;
  logic [CW-1:0]    w_count;
  logic [EW-1:0]    w_head;
  logic [1:0]       w_head_port;
  logic [DLY_W-1:0] w_head_dly;
  logic [WIDTH-1:0] w_head_data;

  assign w_wr    = bus.cs & bus.wen;
  assign w_push  = w_wr & (bus.addr == c_reg_cmd);
  assign w_flush = w_wr & (bus.addr == c_reg_ctrl) & bus.din[c_ctrl_flush];

  assign w_head_port = w_head[EW-1 -: 2];
  assign w_head_dly  = w_head[WIDTH +: DLY_W];
  assign w_head_data = w_head[WIDTH-1:0];

  gpio_seq_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata ({bus.din[1:0], bus.din[DLY_W+1:2], r_data}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_run  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_wr) begin
      case (bus.addr)
        c_reg_data: r_data <= bus.din;
        c_reg_cmd:  if (w_full) r_ovf <= 1'b1;
        c_reg_ctrl: r_run  <= bus.din[c_ctrl_run];
        default:    r_ovf  <= 1'b0;
      endcase
    end
  end

  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      c_reg_data: bus.dout = r_data;
      c_reg_cmd:  if (!w_empty) bus.dout[DLY_W+1:0] = {w_head_dly, w_head_port};
      c_reg_ctrl: bus.dout[c_ctrl_run] = r_run;
      default: begin
        bus.dout[c_st_empty]           = w_empty;
        bus.dout[c_st_full]            = w_full;
        bus.dout[c_st_busy]            = (r_state != c_fsm_idle);
        bus.dout[c_st_ovf]             = r_ovf;
        bus.dout[c_st_cnt_lsb +: CW]   = w_count;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_fsm_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_fsm_idle:  if (r_run && !w_empty) w_state_nxt = c_fsm_issue;
      // the head being issued is still counted, so another entry means count > 1
      c_fsm_issue: begin
        if (w_head_dly != '0)                     w_state_nxt = c_fsm_wait;
        else if (r_run && (w_count > CW'(1)))     w_state_nxt = c_fsm_issue;
        else                                      w_state_nxt = c_fsm_idle;
      end
      c_fsm_wait:  if (r_cnt == DLY_W'(1))
                     w_state_nxt = (r_run && !w_empty) ? c_fsm_issue : c_fsm_idle;
      default:     w_state_nxt = c_fsm_idle;
    endcase
    if (w_flush) w_state_nxt = c_fsm_idle;
  end

  always_comb begin
    g_cs   = 1'b0;
    g_wen  = 1'b0;
    g_addr = r_last_addr;
    g_din  = r_last_din;
    w_pop  = 1'b0;
    done   = r_idle_entry & w_empty;
    if (r_state == c_fsm_issue) begin
      g_cs   = 1'b1;
      g_wen  = 1'b1;
      g_addr = w_head_port;
      g_din  = w_head_data;
      w_pop  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_last_addr  <= '0;
      r_last_din   <= '0;
      r_idle_entry <= 1'b0;
    end else begin
      if (r_state == c_fsm_issue) begin
        r_cnt       <= w_head_dly;
        r_last_addr <= w_head_port;
        r_last_din  <= w_head_data;
      end else if (r_state == c_fsm_wait) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // a flush-driven return to IDLE must not raise done
      r_idle_entry <= (r_state != c_fsm_idle) && (w_state_nxt == c_fsm_idle) && !w_flush;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_out_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gpio_out_seq : directed bench with write/done scoreboards               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_gpio_out_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        g_cs, g_wen, done;
  logic [1:0]  g_addr;
  logic [31:0] g_din;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] data;
    int          at;
  } wr_exp_t;

  wr_exp_t q_wr[$];
  int      q_done[$];

  gpio_out_seq_if #(.WIDTH(32)) bus ();

  gpio_out_seq #(.WIDTH(32), .DEPTH(8), .DLY_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .g_cs   (g_cs),
    .g_wen  (g_wen),
    .g_addr (g_addr),
    .g_din  (g_din),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard side: every issued write and done pulse must match the head of its queue
  always @(negedge clk) begin
    if (g_wen) begin
      if (q_wr.size() == 0) check("unexpected_wen", 64'(g_wen), 64'd0);
      else begin
        wr_exp_t e;
        e = q_wr.pop_front();
        check("wr_cs",    64'(g_cs),   64'd1);
        check("wr_port",  64'(g_addr), 64'(e.port));
        check("wr_data",  64'(g_din),  64'(e.data));
        check("wr_cycle", 64'(cyc),    64'(e.at));
      end
    end
    if (done) begin
      if (q_done.size() == 0) check("unexpected_done", 64'(done), 64'd0);
      else check("done_cycle", 64'(cyc), 64'(q_done.pop_front()));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d, output int n);
    n        = cyc;
    bus.cs   = 1'b1;
    bus.wen  = 1'b1;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk); #1;
    bus.cs   = 1'b0;
    bus.wen  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.cs   = 1'b1;
    bus.wen  = 1'b0;
    bus.addr = a;
    #1;
    v = bus.dout;
    #1;
    bus.cs   = 1'b0;
  endtask

  task automatic push(input logic [1:0] p, input int dly, input logic [31:0] d, output int n);
    int t;
    wr(2'd0, d, t);
    wr(2'd1, 32'({dly[15:0], p}), n);
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [1:0] p, input logic [31:0] d, input int at);
    wr_exp_t e;
    e.port = p;
    e.data = d;
    e.at   = at;
    q_wr.push_back(e);
  endtask

  task automatic drained(input string tag);
    check({tag, "_wr_q_empty"},   64'(q_wr.size()),   64'd0);
    check({tag, "_done_q_empty"}, 64'(q_done.size()), 64'd0);
  endtask

  initial begin
    int n, r, s;
    logic [31:0] v;
    bus.cs = 1'b0; bus.wen = 1'b0; bus.addr = 2'd0; bus.din = '0;

    // power-on reset state
    #2;
    check("rst_g_wen",  64'(g_wen),  64'd0);
    check("rst_g_addr", 64'(g_addr), 64'd0);
    check("rst_g_din",  64'(g_din),  64'd0);
    check("rst_done",   64'(done),   64'd0);
    rd(2'd3, v); check("rst_status", 64'(v), 64'h001);
    rd(2'd0, v); check("rst_data",   64'(v), 64'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(1);

    // single immediate write with delay 0
    wr(2'd2, 32'd1, n);
    push(2'd2, 0, 32'hA5, n);
    exp_wr(2'd2, 32'hA5, n + 2);
    q_done.push_back(n + 3);
    idle(6);
    drained("t2");

    // three queued entries, delays 3,0,5
    wr(2'd2, 32'd0, n);
    push(2'd1, 3, 32'h11, n);
    push(2'd2, 0, 32'h22, n);
    push(2'd3, 5, 32'h33, n);
    wr(2'd2, 32'd1, r);
    exp_wr(2'd1, 32'h11, r + 2);
    exp_wr(2'd2, 32'h22, r + 6);
    exp_wr(2'd3, 32'h33, r + 7);
    q_done.push_back(r + 13);
    idle(20);
    drained("t3");

    // overflow on the ninth push, cleared by a STATUS write
    wr(2'd2, 32'd0, n);
    for (int i = 0; i < 9; i++) push(2'(i % 4), 1, 32'(i), n);
    rd(2'd3, v); check("ovf_status",  64'(v), 64'h80A);
    rd(2'd1, v); check("head_cmd",    64'(v), 64'h4);
    rd(2'd0, v); check("data_rb",     64'(v), 64'h8);
    wr(2'd3, 32'd0, n);
    rd(2'd3, v); check("ovf_cleared", 64'(v), 64'h802);
    wr(2'd2, 32'd2, n);
    rd(2'd3, v); check("flush_status", 64'(v), 64'h001);
    rd(2'd2, v); check("ctrl_rb",      64'(v), 64'h0);
    idle(3);
    drained("t4");

    // run cleared mid-WAIT, then resumed
    for (int i = 0; i < 4; i++) push(2'(i), 4, 32'h50 + 32'(i), n);
    wr(2'd2, 32'd1, r);
    exp_wr(2'd0, 32'h50, r + 2);
    idle(2);
    wr(2'd2, 32'd0, n);
    idle(2);
    rd(2'd3, v); check("pause_busy",   64'(v), 64'h304);
    idle(1);
    rd(2'd3, v); check("pause_idle",   64'(v), 64'h300);
    idle(5);
    wr(2'd2, 32'd1, s);
    exp_wr(2'd1, 32'h51, s + 2);
    exp_wr(2'd2, 32'h52, s + 7);
    exp_wr(2'd3, 32'h53, s + 12);
    q_done.push_back(s + 17);
    idle(22);
    drained("t5");

    // flush during WAIT with three entries still queued
    wr(2'd2, 32'd0, n);
    for (int i = 0; i < 4; i++) push(2'(3 - i), 6, 32'h60 + 32'(i), n);
    wr(2'd2, 32'd1, r);
    exp_wr(2'd3, 32'h60, r + 2);
    idle(2);
    wr(2'd2, 32'd3, n);
    rd(2'd3, v); check("flush_wait_status", 64'(v), 64'h001);
    idle(12);
    drained("t6");

    // asynchronous reset in the middle of a WAIT
    wr(2'd2, 32'd0, n);
    push(2'd3, 10, 32'hDEAD, n);
    push(2'd1, 10, 32'hBEEF, n);
    wr(2'd2, 32'd1, r);
    exp_wr(2'd3, 32'hDEAD, r + 2);
    idle(3);
    rd(2'd3, v); check("pre_rst_busy", 64'(v), 64'h104);
    reset = 1'b0;
    #1;
    check("arst_g_wen",  64'(g_wen),  64'd0);
    check("arst_g_cs",   64'(g_cs),   64'd0);
    check("arst_g_addr", 64'(g_addr), 64'd0);
    check("arst_g_din",  64'(g_din),  64'd0);
    check("arst_done",   64'(done),   64'd0);
    rd(2'd3, v); check("arst_status", 64'(v), 64'h001);
    rd(2'd2, v); check("arst_ctrl",   64'(v), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(15);
    rd(2'd3, v); check("post_rst_status", 64'(v), 64'h001);
    drained("t1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
